// File: rtl/read_queue_pkg.sv
// Shared helpers for the page's stream width converters (read_queue and its
// transmit-side down-converter counterpart).
package read_queue_pkg;

  localparam int unsigned DEF_IN_WIDTH  = 32;
  localparam int unsigned DEF_OUT_WIDTH = 128;

  // Width of a lane counter covering 0..r-1, never narrower than one bit.
  function automatic int unsigned lane_cnt_bits(input int unsigned r);
    int unsigned b;
    b = $clog2(r);
    return (b < 1) ? 1 : b;
  endfunction

  // Wide side must be an integer multiple (>= 2) of the narrow side.
  function automatic bit width_ratio_ok(input int unsigned narrow_w, input int unsigned wide_w);
    return (narrow_w != 0) && ((wide_w % narrow_w) == 0) && ((wide_w / narrow_w) >= 2);
  endfunction

endpackage

// File: rtl/read_queue.sv
// Receive-side width up-converter: packs OUT_WIDTH/IN_WIDTH consecutive input
// words into one output word, first-arrived word in the least-significant lane.
// Ports:
//   clk, reset_n          - clock, asynchronous active-low reset
//   din, vld_in           - narrow input stream from the leaf interface
//   rdy_upward            - registered ready back to the leaf interface
//   dout, vld_out         - registered wide output stream to the user kernel
//   rdy_downward          - user kernel ready
//   ap_start              - page start; sticky arm of the input side
module read_queue
  import read_queue_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = DEF_IN_WIDTH,
  parameter int unsigned OUT_WIDTH = DEF_OUT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [IN_WIDTH-1:0]  din,
  input  logic                 vld_in,
  output logic                 rdy_upward,
  output logic [OUT_WIDTH-1:0] dout,
  output logic                 vld_out,
  input  logic                 rdy_downward,
  input  logic                 ap_start
);

  localparam int unsigned R  = OUT_WIDTH / IN_WIDTH;
  localparam int unsigned CW = lane_cnt_bits(R);
  localparam logic [CW-1:0] LAST_LANE = CW'(R - 1);

  if (!width_ratio_ok(IN_WIDTH, OUT_WIDTH)) begin : g_bad_ratio
    $error("read_queue: OUT_WIDTH must be an integer multiple (>= 2) of IN_WIDTH");
  end

  logic                 armed, armed_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [OUT_WIDTH-1:0] acc, acc_nxt;
  logic [OUT_WIDTH-1:0] dout_nxt;
  logic                 vld_nxt, rdy_nxt;
  logic                 accept, consume;

  assign accept  = vld_in & rdy_upward;
  assign consume = vld_out & rdy_downward;

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed      <= 1'b0;
      cnt        <= '0;
      acc        <= '0;
      dout       <= '0;
      vld_out    <= 1'b0;
      rdy_upward <= 1'b0;
    end else begin
      armed      <= armed_nxt;
      cnt        <= cnt_nxt;
      acc        <= acc_nxt;
      dout       <= dout_nxt;
      vld_out    <= vld_nxt;
      rdy_upward <= rdy_nxt;
    end
  end

  // Lane fill, output load and ready look-ahead.
  always_comb begin
    armed_nxt = armed | ap_start;
    cnt_nxt   = cnt;
    acc_nxt   = acc;
    dout_nxt  = dout;
    vld_nxt   = vld_out;

    if (consume) vld_nxt = 1'b0;

    if (accept) begin
      for (int unsigned i = 0; i < R; i++) begin
        if (cnt == CW'(i)) acc_nxt[i*IN_WIDTH +: IN_WIDTH] = din;
      end
      if (cnt == LAST_LANE) begin
        // A load wins over a same-cycle consume: the new word replaces the old.
        dout_nxt = acc_nxt;
        vld_nxt  = 1'b1;
        cnt_nxt  = '0;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end

    // Refuse input only when the last lane would land on an occupied output.
    rdy_nxt = armed_nxt & ~((cnt_nxt == LAST_LANE) & vld_nxt);
  end

endmodule

// File: tb/tb_read_queue.sv
// Self-checking bench for read_queue (IN_WIDTH=32, OUT_WIDTH=128, R=4).
module tb_read_queue;

  localparam int unsigned IW = 32;
  localparam int unsigned OW = 128;
  localparam int unsigned R  = OW / IW;

  logic          clk;
  logic          reset_n;
  logic [IW-1:0] din;
  logic          vld_in;
  logic          rdy_upward;
  logic [OW-1:0] dout;
  logic          vld_out;
  logic          rdy_downward;
  logic          ap_start;

  read_queue #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .din          (din),
    .vld_in       (vld_in),
    .rdy_upward   (rdy_upward),
    .dout         (dout),
    .vld_out      (vld_out),
    .rdy_downward (rdy_downward),
    .ap_start     (ap_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          ap_start;
    logic          vld_in;
    logic          rdy_dn;
    logic [IW-1:0] din;
    logic          exp_rdy;
    logic          exp_vld;
    logic [OW-1:0] exp_dout;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];

  int checks   = 0;
  int failures = 0;
  int n_out    = 0;
  logic [IW-1:0] in_q [$];

  function automatic vec_t mk(input logic s, input logic v, input logic rd, input logic [IW-1:0] d,
                              input logic er, input logic ev, input logic [OW-1:0] ed);
    vec_t t;
    t.ap_start = s; t.vld_in = v; t.rdy_dn = rd; t.din = d;
    t.exp_rdy = er; t.exp_vld = ev; t.exp_dout = ed;
    return t;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard bookkeeping for the handshakes of the coming edge, then advance.
  task automatic cycle();
    logic [OW-1:0] exp;
    if (vld_out && rdy_downward) begin
      n_out++;
      if (in_q.size() >= R) begin
        for (int j = 0; j < int'(R); j++) exp[j*IW +: IW] = in_q.pop_front();
        chkw("sb_data", dout, exp);
      end else begin
        chkw("sb_underflow", OW'(in_q.size()), OW'(R));
      end
    end
    if (vld_in && rdy_upward) in_q.push_back(din);
    @(posedge clk);
    #1;
  endtask

  logic [OW-1:0] w1, wa, wb, wc;
  logic [IW-1:0] aw [8];
  int out_base;

  initial begin
    w1 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    for (int i = 0; i < 8; i++) aw[i] = 32'hA0000001 + 32'(i);
    wa = {aw[3], aw[2], aw[1], aw[0]};
    wb = {aw[7], aw[6], aw[5], aw[4]};
    wc = {32'hC0000004, 32'hC0000003, 32'hC0000002, 32'hC0000001};

    // Arm check: ap_start low for 10 cycles with valid input pending.
    for (int i = 0; i < 10; i++) vecs[i] = mk(0, 1, 1, 32'hDEAD0000 + 32'(i), 0, 0, '0);
    vecs[10] = mk(1, 0, 1, '0,           1, 0, '0);
    vecs[11] = mk(0, 1, 1, 32'h11111111, 1, 0, '0);
    vecs[12] = mk(0, 1, 1, 32'h22222222, 1, 0, '0);
    vecs[13] = mk(0, 1, 1, 32'h33333333, 1, 0, '0);
    vecs[14] = mk(0, 1, 1, 32'h44444444, 1, 1, w1);
    vecs[15] = mk(0, 0, 1, '0,           1, 0, w1);
    // Backpressure: 8 words with the kernel stalled.
    vecs[16] = mk(0, 1, 0, aw[0], 1, 0, w1);
    vecs[17] = mk(0, 1, 0, aw[1], 1, 0, w1);
    vecs[18] = mk(0, 1, 0, aw[2], 1, 0, w1);
    vecs[19] = mk(0, 1, 0, aw[3], 1, 1, wa);
    vecs[20] = mk(0, 1, 0, aw[4], 1, 1, wa);
    vecs[21] = mk(0, 1, 0, aw[5], 1, 1, wa);
    vecs[22] = mk(0, 1, 0, aw[6], 0, 1, wa);
    vecs[23] = mk(0, 1, 0, aw[7], 0, 1, wa);
    vecs[24] = mk(0, 1, 0, aw[7], 0, 1, wa);
    vecs[25] = mk(0, 1, 1, aw[7], 1, 0, wa);
    vecs[26] = mk(0, 1, 1, aw[7], 1, 1, wb);
    vecs[27] = mk(0, 0, 1, '0,    1, 0, wb);

    reset_n = 1'b0; din = '0; vld_in = 1'b0; rdy_downward = 1'b0; ap_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk1("reset_rdy", rdy_upward, 1'b0);
    chk1("reset_vld", vld_out, 1'b0);
    chkw("reset_dout", dout, '0);

    for (int i = 0; i < NV; i++) begin
      ap_start = vecs[i].ap_start; vld_in = vecs[i].vld_in;
      rdy_downward = vecs[i].rdy_dn; din = vecs[i].din;
      cycle();
      chk1($sformatf("vec%0d_rdy", i), rdy_upward, vecs[i].exp_rdy);
      chk1($sformatf("vec%0d_vld", i), vld_out, vecs[i].exp_vld);
      chkw($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
    end

    // Full rate: 64 back-to-back words, output every 4th accept + 1.
    out_base = n_out;
    vld_in = 1'b1; rdy_downward = 1'b1; ap_start = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      din = 32'h10000000 | 32'(k);
      cycle();
      chk1($sformatf("full_rdy%0d", k), rdy_upward, 1'b1);
      chk1($sformatf("full_vld%0d", k), vld_out, (k % 4) == 0);
    end
    vld_in = 1'b0;
    cycle();
    chkw("full_out_count", OW'(n_out - out_base), OW'(16));

    // Reset in the middle of a packet.
    vld_in = 1'b1;
    din = 32'hBBBB0001; cycle();
    din = 32'hBBBB0002; cycle();
    vld_in = 1'b0;
    reset_n = 1'b0;
    #1;
    chk1("midrst_rdy", rdy_upward, 1'b0);
    chk1("midrst_vld", vld_out, 1'b0);
    chkw("midrst_dout", dout, '0);
    in_q.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    vld_in = 1'b1; din = 32'hBBBB0003;
    cycle();
    chk1("midrst_unarmed_rdy", rdy_upward, 1'b0);
    vld_in = 1'b0; ap_start = 1'b1;
    cycle();
    ap_start = 1'b0;
    chk1("midrst_rearm_rdy", rdy_upward, 1'b1);
    vld_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      din = 32'hC0000001 + 32'(k);
      cycle();
    end
    vld_in = 1'b0;
    chk1("midrst_vld_out", vld_out, 1'b1);
    chkw("midrst_dout_new", dout, wc);

    // Random traffic with scoreboard.
    for (int n = 0; n < 10000; n++) begin
      vld_in = ($urandom_range(0, 3) != 0);
      rdy_downward = ($urandom_range(0, 2) != 0);
      din = $urandom;
      cycle();
    end
    vld_in = 1'b0; rdy_downward = 1'b1;
    repeat (3) cycle();
    chk1("drain_vld", vld_out, 1'b0);
    chk1("drain_residue", in_q.size() < R, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
